// File: rtl/apb_bus_arbiter.sv
`default_nettype none
// =============================================================================
// apb_bus_arbiter : shares one APB master between two requesters, with timeout
//                   recovery and DRAIN of late responses.
// Revision: 1.0
// =============================================================================
module apb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
  parameter bit          FIXED_PRIO     = 1'b0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        m0_transfer,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_transfer,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        transfer,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned   c_CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_last;
  logic               r_grant;
  logic               r_timed_out;
  logic               r_timeout_err;
  logic               r_write;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_m0_rdata;
  logic [31:0]        r_m1_rdata;

  logic               w_any_req;
  logic               w_win;
  logic               w_ready_hit;
  logic               w_timeout;

  always_ff @(posedge PCLK) begin
    if (!PRESET) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_any_req    = m0_transfer | m1_transfer;
    w_ready_hit  = 1'b0;
    w_timeout    = 1'b0;
    // Tie goes to the requester not served last unless fixed priority is selected.
    if (m0_transfer && m1_transfer) w_win = FIXED_PRIO ? 1'b0 : ~r_last;
    else                            w_win = m1_transfer;

    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (ready) begin
          w_ready_hit  = 1'b1;
          w_next_state = S_RESP;
        end else if (r_cnt == c_CNT_MAX) begin
          w_timeout    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = r_timed_out ? S_DRAIN : S_IDLE;
      S_DRAIN: if (ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_timed_out <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_win;
            r_cnt   <= '0;
            r_write <= w_win ? m1_write : m0_write;
            r_addr  <= w_win ? m1_addr  : m0_addr;
            r_wdata <= w_win ? m1_wdata : m0_wdata;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (w_ready_hit || w_timeout) begin
            if (r_grant) r_m1_rdata <= w_ready_hit ? rdata : ERR_DATA;
            else         r_m0_rdata <= w_ready_hit ? rdata : ERR_DATA;
          end
          if (w_timeout) r_timed_out <= 1'b1;
        end
        S_RESP:  r_last <= r_grant;
        // The late response of a timed-out transfer is consumed here and dropped.
        S_DRAIN: if (ready) r_timed_out <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET)        r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
    else if (err_clr)   r_timeout_err <= 1'b0;
  end

  assign transfer    = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);
  assign m0_ready    = (r_state == S_RESP) && !r_grant;
  assign m1_ready    = (r_state == S_RESP) &&  r_grant;
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign write       = r_write;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_bus_arbiter.sv
`default_nettype none
// =============================================================================
// tb_apb_bus_arbiter : directed test of round-robin and fixed-priority arbiters
// Revision: 1.0
// =============================================================================
module tb_apb_bus_arbiter;

  logic        clk = 1'b0;
  logic        PRESET;
  logic        m0_transfer, m0_write, m1_transfer, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] rdata;
  logic        ready, err_clr;

  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_addr, rr_wdata;
  logic        rr_m0_ready, rr_m1_ready, rr_transfer, rr_write, rr_grant, rr_busy, rr_terr;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_addr, fp_wdata;
  logic        fp_m0_ready, fp_m1_ready, fp_transfer, fp_write, fp_grant, fp_busy, fp_terr;

  int checks   = 0;
  int failures = 0;
  int n_xfer   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rr_transfer) n_xfer++;

  apb_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF), .FIXED_PRIO(1'b0)) u_rr (
    .PCLK(clk), .PRESET(PRESET),
    .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(rr_m0_rdata), .m0_ready(rr_m0_ready),
    .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(rr_m1_rdata), .m1_ready(rr_m1_ready),
    .transfer(rr_transfer), .write(rr_write), .addr(rr_addr), .wdata(rr_wdata),
    .rdata(rdata), .ready(ready), .grant(rr_grant), .busy(rr_busy),
    .timeout_err(rr_terr), .err_clr(err_clr)
  );

  apb_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF), .FIXED_PRIO(1'b1)) u_fp (
    .PCLK(clk), .PRESET(PRESET),
    .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(fp_m0_rdata), .m0_ready(fp_m0_ready),
    .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(fp_m1_rdata), .m1_ready(fp_m1_ready),
    .transfer(fp_transfer), .write(fp_write), .addr(fp_addr), .wdata(fp_wdata),
    .rdata(rdata), .ready(ready), .grant(fp_grant), .busy(fp_busy),
    .timeout_err(fp_terr), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b0;
    tick();
    tick();
    checks++;
    if ({rr_transfer, rr_write, rr_m0_ready, rr_m1_ready, rr_grant, rr_busy, rr_terr} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=0000000",
               {rr_transfer, rr_write, rr_m0_ready, rr_m1_ready, rr_grant, rr_busy, rr_terr});
    end
    checks++;
    if ({rr_addr, rr_wdata, rr_m0_rdata, rr_m1_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data actual=%h required=0", {rr_addr, rr_wdata, rr_m0_rdata, rr_m1_rdata});
    end
    checks++;
    if ({fp_transfer, fp_busy, fp_grant, fp_terr} !== 4'b0) begin
      failures++;
      $display("FAIL reset_fp actual=%b required=0000", {fp_transfer, fp_busy, fp_grant, fp_terr});
    end
    PRESET = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int lat;
    int x0;
    x0 = n_xfer;
    m0_transfer = 1'b1; m0_write = 1'b0; m0_addr = 32'h1000_0000; m0_wdata = 32'h0;
    lat = 1;
    tick(); lat++;
    checks++;
    if (rr_transfer !== 1'b1 || rr_addr !== 32'h1000_0000 || rr_grant !== 1'b0 || rr_busy !== 1'b1) begin
      failures++;
      $display("FAIL read_issue actual=xfer%b addr%h gnt%b busy%b required=xfer1 addr10000000 gnt0 busy1",
               rr_transfer, rr_addr, rr_grant, rr_busy);
    end
    tick(); lat++;
    checks++;
    if (rr_transfer !== 1'b0) begin
      failures++;
      $display("FAIL read_xfer_one_cycle actual=%b required=0", rr_transfer);
    end
    tick(); lat++;
    ready = 1'b1; rdata = 32'h0000_00A5;
    tick(); lat++;
    ready = 1'b0; rdata = 32'h0;
    checks++;
    if (rr_m0_ready !== 1'b1 || rr_m0_rdata !== 32'h0000_00A5 || rr_m1_ready !== 1'b0) begin
      failures++;
      $display("FAIL read_resp actual=rdy%b data%h m1rdy%b required=rdy1 data000000a5 m1rdy0",
               rr_m0_ready, rr_m0_rdata, rr_m1_ready);
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL read_latency actual=%0d required=5", lat);
    end
    m0_transfer = 1'b0;
    tick();
    checks++;
    if (rr_m0_ready !== 1'b0 || rr_busy !== 1'b0 || rr_m0_rdata !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL read_after actual=rdy%b busy%b data%h required=rdy0 busy0 data000000a5",
               rr_m0_ready, rr_busy, rr_m0_rdata);
    end
    checks++;
    if (n_xfer - x0 != 1) begin
      failures++;
      $display("FAIL read_xfer_count actual=%0d required=1", n_xfer - x0);
    end
  endtask

  task automatic test_m1_write();
    m1_transfer = 1'b1; m1_write = 1'b1; m1_addr = 32'h1000_2000; m1_wdata = 32'hCAFE_F00D;
    tick();
    checks++;
    if (rr_transfer !== 1'b1 || rr_write !== 1'b1 || rr_wdata !== 32'hCAFE_F00D ||
        rr_addr !== 32'h1000_2000 || rr_grant !== 1'b1) begin
      failures++;
      $display("FAIL write_issue actual=xfer%b wr%b wd%h addr%h gnt%b required=xfer1 wr1 wdcafef00d addr10002000 gnt1",
               rr_transfer, rr_write, rr_wdata, rr_addr, rr_grant);
    end
    tick();
    ready = 1'b1; rdata = 32'h0000_1234;
    tick();
    ready = 1'b0; rdata = 32'h0;
    checks++;
    if (rr_m1_ready !== 1'b1 || rr_m0_ready !== 1'b0 || rr_m1_rdata !== 32'h0000_1234) begin
      failures++;
      $display("FAIL write_resp actual=m1rdy%b m0rdy%b data%h required=m1rdy1 m0rdy0 data00001234",
               rr_m1_ready, rr_m0_ready, rr_m1_rdata);
    end
    m1_transfer = 1'b0; m1_write = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_rr;
    m0_transfer = 1'b1; m0_write = 1'b0; m0_addr = 32'h2000_0000; m0_wdata = 32'h0000_0A0A;
    m1_transfer = 1'b1; m1_write = 1'b0; m1_addr = 32'h3000_0000; m1_wdata = 32'h0000_0B0B;
    exp_rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rr_transfer !== 1'b1 || rr_grant !== exp_rr ||
          rr_addr !== (exp_rr ? 32'h3000_0000 : 32'h2000_0000) ||
          rr_wdata !== (exp_rr ? 32'h0000_0B0B : 32'h0000_0A0A)) begin
        failures++;
        $display("FAIL rr_grant_%0d actual=xfer%b gnt%b addr%h wd%h required=xfer1 gnt%b", i,
                 rr_transfer, rr_grant, rr_addr, rr_wdata, exp_rr);
      end
      checks++;
      if (fp_grant !== 1'b0 || fp_addr !== 32'h2000_0000) begin
        failures++;
        $display("FAIL fp_grant_%0d actual=gnt%b addr%h required=gnt0 addr20000000", i, fp_grant, fp_addr);
      end
      tick();
      ready = 1'b1; rdata = 32'h100 + i;
      tick();
      ready = 1'b0;
      checks++;
      if (rr_m0_ready !== ~exp_rr || rr_m1_ready !== exp_rr) begin
        failures++;
        $display("FAIL rr_ready_%0d actual=m0%b m1%b required=m0%b m1%b", i,
                 rr_m0_ready, rr_m1_ready, ~exp_rr, exp_rr);
      end
      tick();
      exp_rr = ~exp_rr;
    end
    m0_transfer = 1'b0; m1_transfer = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    m0_transfer = 1'b1; m0_write = 1'b0; m0_addr = 32'h1000_0004;
    m1_write = 1'b0; m1_addr = 32'h1000_0008;
    tick();
    checks++;
    if (rr_transfer !== 1'b1 || rr_grant !== 1'b0) begin
      failures++;
      $display("FAIL to_issue actual=xfer%b gnt%b required=xfer1 gnt0", rr_transfer, rr_grant);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (rr_m0_ready !== 1'b0 || rr_busy !== 1'b1) begin
        failures++;
        $display("FAIL to_wait_%0d actual=rdy%b busy%b required=rdy0 busy1", i, rr_m0_ready, rr_busy);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (rr_m0_ready !== 1'b1 || rr_m0_rdata !== 32'hDEAD_BEEF || rr_terr !== 1'b1) begin
      failures++;
      $display("FAIL to_resp actual=rdy%b data%h err%b required=rdy1 datadeadbeef err1",
               rr_m0_ready, rr_m0_rdata, rr_terr);
    end
    m0_transfer = 1'b0;
    m1_transfer = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rr_transfer !== 1'b0 || rr_busy !== 1'b1 || rr_grant !== 1'b0 || rr_terr !== 1'b1) begin
        failures++;
        $display("FAIL to_drain_%0d actual=xfer%b busy%b gnt%b err%b required=xfer0 busy1 gnt0 err1", i,
                 rr_transfer, rr_busy, rr_grant, rr_terr);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (rr_terr !== 1'b0 || fp_terr !== 1'b0) begin
      failures++;
      $display("FAIL to_err_clr actual=%b%b required=00", rr_terr, fp_terr);
    end
    ready = 1'b1; rdata = 32'h5555_5555;
    tick();
    ready = 1'b0; rdata = 32'h0;
    checks++;
    if (rr_busy !== 1'b0 || rr_m0_rdata !== 32'hDEAD_BEEF || rr_transfer !== 1'b0) begin
      failures++;
      $display("FAIL to_drained actual=busy%b data%h xfer%b required=busy0 datadeadbeef xfer0",
               rr_busy, rr_m0_rdata, rr_transfer);
    end
    tick();
    checks++;
    if (rr_transfer !== 1'b1 || rr_grant !== 1'b1 || rr_addr !== 32'h1000_0008) begin
      failures++;
      $display("FAIL to_m1_grant actual=xfer%b gnt%b addr%h required=xfer1 gnt1 addr10000008",
               rr_transfer, rr_grant, rr_addr);
    end
    tick();
    ready = 1'b1; rdata = 32'h0000_0077;
    tick();
    ready = 1'b0;
    checks++;
    if (rr_m1_ready !== 1'b1 || rr_m1_rdata !== 32'h0000_0077) begin
      failures++;
      $display("FAIL to_m1_resp actual=rdy%b data%h required=rdy1 data00000077", rr_m1_ready, rr_m1_rdata);
    end
    m1_transfer = 1'b0;
    tick();
  endtask

  task automatic test_ready_at_expiry();
    m0_transfer = 1'b1; m0_write = 1'b0; m0_addr = 32'h1000_000C;
    tick();
    for (int i = 1; i <= 8; i++) tick();
    ready = 1'b1; rdata = 32'h0BAD_CAFE;
    tick();
    ready = 1'b0; rdata = 32'h0;
    checks++;
    if (rr_m0_ready !== 1'b1 || rr_m0_rdata !== 32'h0BAD_CAFE || rr_terr !== 1'b0) begin
      failures++;
      $display("FAIL expiry_resp actual=rdy%b data%h err%b required=rdy1 data0badcafe err0",
               rr_m0_ready, rr_m0_rdata, rr_terr);
    end
    m0_transfer = 1'b0;
    tick();
    checks++;
    if (rr_busy !== 1'b0) begin
      failures++;
      $display("FAIL expiry_no_drain actual=busy%b required=busy0", rr_busy);
    end
  endtask

  task automatic test_reset_in_wait();
    m0_transfer = 1'b1; m0_write = 1'b0; m0_addr = 32'h4000_0000; m0_wdata = 32'h0000_0044;
    m1_transfer = 1'b1; m1_write = 1'b1; m1_addr = 32'h5000_0000; m1_wdata = 32'h0000_0055;
    tick();
    checks++;
    if (rr_grant !== 1'b1 || rr_write !== 1'b1) begin
      failures++;
      $display("FAIL rw_pre_grant actual=gnt%b wr%b required=gnt1 wr1", rr_grant, rr_write);
    end
    tick();
    PRESET = 1'b0;
    tick();
    checks++;
    if ({rr_transfer, rr_write, rr_m0_ready, rr_m1_ready, rr_grant, rr_busy, rr_terr} !== 7'b0 ||
        {rr_addr, rr_wdata, rr_m0_rdata, rr_m1_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL rw_reset actual=%b %h required=0",
               {rr_transfer, rr_write, rr_m0_ready, rr_m1_ready, rr_grant, rr_busy, rr_terr},
               {rr_addr, rr_wdata, rr_m0_rdata, rr_m1_rdata});
    end
    PRESET = 1'b1;
    tick();
    checks++;
    if (rr_transfer !== 1'b1 || rr_grant !== 1'b0 || rr_addr !== 32'h4000_0000) begin
      failures++;
      $display("FAIL rw_first_tie actual=xfer%b gnt%b addr%h required=xfer1 gnt0 addr40000000",
               rr_transfer, rr_grant, rr_addr);
    end
    tick();
    ready = 1'b1; rdata = 32'h0000_0099;
    tick();
    ready = 1'b0;
    checks++;
    if (rr_m0_ready !== 1'b1 || rr_m0_rdata !== 32'h0000_0099) begin
      failures++;
      $display("FAIL rw_served actual=rdy%b data%h required=rdy1 data00000099", rr_m0_ready, rr_m0_rdata);
    end
    m0_transfer = 1'b0; m1_transfer = 1'b0;
    tick();
  endtask

  initial begin
    PRESET = 1'b0; err_clr = 1'b0; ready = 1'b0; rdata = 32'h0;
    m0_transfer = 1'b0; m0_write = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_transfer = 1'b0; m1_write = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    #1;
    test_reset();
    test_single_read();
    test_m1_write();
    test_round_robin();
    test_timeout();
    test_ready_at_expiry();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_bus_arbiter.md
# apb_bus_arbiter

Two-requester arbiter that shares the single APB master (transfer/ready/write/addr/wdata/rdata interface) between the CPU data port (requester 0) and a second bus master such as a DMA engine (requester 1). It sits between the requesters and the APB master. It serialises transactions, latches each granted request, and issues a one-cycle `transfer` pulse to the APB master. It returns `rdata`/`ready` only to the granted requester and recovers from peripherals that never assert ready.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: WAIT cycles allowed before a forced error response (≥2).
- `ERR_DATA`, 32'hDEAD_BEEF: rdata returned on timeout.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = requester 0 always wins ties.

Ports:
- `PCLK`  in  1  clock; all logic on rising edge.
- `PRESET`  in  1  reset, synchronous, active-low.
- `m0_transfer`, `m1_transfer`  in  1  request; level, held until the matching `mN_ready`.
- `m0_write`, `m1_write`  in  1  1 = write; stable while request is high.
- `m0_addr`, `m1_addr`  in  32  address; stable while request is high.
- `m0_wdata`, `m1_wdata`  in  32  write data; stable while request is high.
- `m0_rdata`, `m1_rdata`  out  32  registered read data; valid when `mN_ready` = 1.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `transfer`  out  1  one-cycle start pulse to the APB master.
- `write`, `addr`, `wdata`  out  1/32/32  latched fields of the granted request.
- `rdata`  in  32  APB master read data; valid with `ready`.
- `ready`  in  1  APB master completion pulse.
- `grant`  out  1  index of the current or most recent owner.
- `busy`  out  1  1 in any state other than IDLE.
- `timeout_err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If any request is high, select a winner and latch its write/addr/wdata into the output registers.
  - Set `grant` to the winner, clear the timeout counter, go to ISSUE.
  - With no request, stay in IDLE.
- Selection:
  - One requester high: it wins.
  - Both high, FIXED_PRIO=0: the requester not served last wins; `last` resets to 1, so requester 0 wins the first tie.
  - Both high, FIXED_PRIO=1: requester 0 wins.
- ISSUE: `transfer`=1 for exactly one cycle, then WAIT.
- WAIT: counter increments each cycle.
  - `ready`=1: register `rdata` into the granted `mN_rdata`, go to RESP.
  - Else counter = TIMEOUT_CYCLES-1: load ERR_DATA, set `timeout_err` and internal `timed_out`, go to RESP.
  - `ready` on the same cycle as timeout expiry: `ready` wins, no error.
- RESP:
  - Granted `mN_ready`=1 for one cycle; the other requester's ready stays 0; update `last`.
  - Next state: DRAIN if `timed_out`, else IDLE.
- DRAIN: wait for `ready`, discard `rdata`, clear `timed_out`, then IDLE. No new grant is issued while in DRAIN.
- The requester drops `mN_transfer` on the edge after its `mN_ready`, so IDLE never re-serves a completed request.
- Write transactions also complete through RESP. `mN_rdata` carries the bus `rdata` as-is, or ERR_DATA on timeout.
- `err_clr` clears `timeout_err`. If `err_clr` and a new timeout occur in the same cycle, set wins.
- `mN_rdata` holds its last value between responses.

## Timing
- Reset (`PRESET`=0 at an edge), from any state: state IDLE and every output 0 (`transfer`, `write`, `addr`, `wdata`, `mN_rdata`, `mN_ready`, `grant`, `busy`, `timeout_err`); `last`=1; counter 0. An in-flight transaction is abandoned; the APB master shares this reset.
- Request first sampled high in IDLE at cycle T:
  - `transfer` high in cycle T+1.
  - WAIT from T+2.
  - Bus `ready` at cycle T+2+k gives `mN_ready` at T+3+k.
  - Minimum request-to-ready latency is 3 cycles.
- Back-to-back: next grant decided in the IDLE cycle after RESP. Throughput is at most one transaction per 4+k cycles.
- Timeout: `mN_ready` with ERR_DATA exactly TIMEOUT_CYCLES+1 cycles after `transfer`.
- `addr`/`write`/`wdata` stay constant from ISSUE through RESP/DRAIN.

## Test plan
- Single read by m0 from 0x1000_0000; APB returns 0x0000_00A5 two cycles after `transfer` -> one `transfer` pulse, `m0_rdata`=0x0000_00A5, `m0_ready` one cycle, latency 5 cycles; `m1_ready` stays 0.
- Both requesters held continuously with FIXED_PRIO=0 -> grant order 0,1,0,1; each `transfer` carries the winner's addr/wdata. With FIXED_PRIO=1 -> grant 0 whenever m0 is requesting.
- m1 write 0xCAFE_F00D to 0x1000_2000 -> `write`=1, `wdata`=0xCAFE_F00D at `transfer`; `m1_ready` pulse after bus `ready`.
- Bus `ready` withheld, TIMEOUT_CYCLES=8 -> `m0_rdata`=0xDEAD_BEEF, `timeout_err`=1; arbiter in DRAIN; m1 request not granted until the late `ready`; `err_clr` clears the flag.
- `ready` on the same cycle as counter = TIMEOUT_CYCLES-1 -> real data returned, `timeout_err` stays 0.
- `PRESET`=0 during WAIT -> next cycle all outputs 0 and state IDLE; a request after reset release is served normally with requester 0 winning the first tie.
